tl_a_rr_arbiter: RTL and testbench

// Two-requester round-robin arbiter for a TileLink-A channel (opcode/param/size/source/address/mask/data/corrupt, 64-bit beat).

---
 rtl/tl_a_rr_arbiter_if.sv | 37 +++
 rtl/tl_a_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_tl_a_rr_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_a_rr_arbiter_if.sv
// TileLink-A channel bundle: one beat of request plus its valid/ready handshake.
// Fields carry a 64-bit data beat with an 8-bit byte mask.
//   valid    master -> slave  beat present
//   ready    slave  -> master beat accepted this cycle
//   opcode   3      A opcode (0 PutFull .. 5 Hint)
//   param    3      A param
//   size     3      lgSize of the whole transfer
//   source   SRC_W  source id
//   address  32     byte address
//   mask     8      byte lane mask
//   data     64     beat data
//   corrupt  1      corrupt flag
// The master modport is the side that drives a request; slave receives it.
interface tl_a_rr_arbiter_if #(
  parameter int SRC_W = 4
);
  logic             valid;
  logic             ready;
  logic [2:0]       opcode;
  logic [2:0]       param;
  logic [2:0]       size;
  logic [SRC_W-1:0] source;
  logic [31:0]      address;
  logic [7:0]       mask;
  logic [63:0]      data;
  logic             corrupt;

  modport master (
    output valid, opcode, param, size, source, address, mask, data, corrupt,
    input  ready
  );

  modport slave (
    input  valid, opcode, param, size, source, address, mask, data, corrupt,
    output ready
  );
endinterface

// File: rtl/tl_a_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one downstream TileLink-A port.
// The datapath is a purely combinational mux (no added latency); a small FSM
// keeps the grant on one requester for every beat of a multi-beat burst and
// freezes the selection while a request is stalled by the downstream side.
//   clock      in   sole clock, rising edge
//   reset_n    in   synchronous active-low reset
//   in0, in1   slave  upstream request ports (in[sel].ready = out.ready)
//   out        master downstream request port
//   out_grant  out  index of the currently selected requester
//   size_err   out  one-cycle pulse after a first beat with size > MAX_SIZE fires
module tl_a_rr_arbiter #(
  parameter int SRC_W    = 4,
  parameter int MAX_SIZE = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  tl_a_rr_arbiter_if.slave  in0,
  tl_a_rr_arbiter_if.slave  in1,
  tl_a_rr_arbiter_if.master out,
  output logic              out_grant,
  output logic              size_err
);

  localparam logic [2:0] MAX_SIZE_L = 3'(MAX_SIZE);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic             prio;
  logic             held;
  logic             lock_sel;
  logic [2:0]       beat_cnt;
  logic             sel;
  logic             fire;
  logic [2:0]       op_mux;
  logic [2:0]       size_mux;
  logic [SRC_W-1:0] src_mux;
  logic [4:0]       nb;
  logic             oversize;

  // Beats in a transfer: only data-carrying opcodes (Put/Arith/Logical)
  // spread over several 8-byte beats; everything else is a single beat.
  function automatic logic [4:0] beats(input logic [2:0] op, input logic [2:0] size);
    if (op <= 3'd3 && size > 3'd3) return 5'd1 << (size - 3'd3);
    return 5'd1;
  endfunction

  // lock_sel doubles as the frozen selection for a stalled IDLE request and
  // the burst owner in LOCKED, so a stalled or locked request never moves.
  always_comb begin
    sel = prio;
    if (!reset_n)                      sel = 1'b0;
    else if (state == LOCKED || held)  sel = lock_sel;
    else if (in0.valid != in1.valid)   sel = in1.valid;
  end

  assign out_grant = sel;

  assign src_mux     = sel ? in1.source : in0.source;
  assign op_mux      = sel ? in1.opcode : in0.opcode;
  assign size_mux    = sel ? in1.size   : in0.size;

  assign out.valid   = reset_n & (sel ? in1.valid : in0.valid);
  assign out.opcode  = op_mux;
  assign out.param   = sel ? in1.param   : in0.param;
  assign out.size    = size_mux;
  assign out.source  = src_mux;
  assign out.address = sel ? in1.address : in0.address;
  assign out.mask    = sel ? in1.mask    : in0.mask;
  assign out.data    = sel ? in1.data    : in0.data;
  assign out.corrupt = sel ? in1.corrupt : in0.corrupt;

  assign in0.ready   = reset_n & ~sel & out.ready;
  assign in1.ready   = reset_n &  sel & out.ready;

  assign fire        = out.valid & out.ready;
  assign nb          = beats(op_mux, size_mux);
  assign oversize    = size_mux > MAX_SIZE_L;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      prio     <= 1'b0;
      held     <= 1'b0;
      lock_sel <= 1'b0;
      beat_cnt <= 3'd0;
      size_err <= 1'b0;
    end else begin
      size_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            held <= 1'b0;
            // An oversized transfer is passed as one beat so the lock can
            // never be loaded with a count wider than beat_cnt.
            if (!oversize && nb > 5'd1) begin
              state    <= LOCKED;
              beat_cnt <= 3'(nb - 5'd1);
              lock_sel <= sel;
            end else begin
              prio     <= ~sel;
              size_err <= oversize;
            end
          end else if (out.valid) begin
            held     <= 1'b1;
            lock_sel <= sel;
          end
        end
        LOCKED: begin
          if (fire) begin
            beat_cnt <= beat_cnt - 3'd1;
            if (beat_cnt == 3'd1) begin
              state <= IDLE;
              prio  <= ~lock_sel;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_a_rr_arbiter.sv
// Bench for tl_a_rr_arbiter: directed scenarios followed by a random phase.
// A driver feeds per-requester beat queues; each presented beat is pushed to
// an expected queue, and an independent monitor checks every downstream cycle
// against a transaction-level model (beat counts, round-robin order, lock).
module tb_tl_a_rr_arbiter;
  localparam int SRC_W    = 4;
  localparam int MAX_SIZE = 6;

  typedef struct {
    logic [2:0]       op;
    logic [2:0]       prm;
    logic [2:0]       sz;
    logic [SRC_W-1:0] src;
    logic [31:0]      adr;
    logic [7:0]       msk;
    logic [63:0]      dat;
    logic             cor;
    int               gap;
  } beat_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset_n;
  logic             out_ready;
  logic             out_grant;
  logic             size_err;
  logic             v[2];
  logic             rdy[2];
  logic [2:0]       f_op[2];
  logic [2:0]       f_prm[2];
  logic [2:0]       f_sz[2];
  logic [SRC_W-1:0] f_src[2];
  logic [31:0]      f_adr[2];
  logic [7:0]       f_msk[2];
  logic [63:0]      f_dat[2];
  logic             f_cor[2];

  tl_a_rr_arbiter_if #(.SRC_W(SRC_W)) i0 ();
  tl_a_rr_arbiter_if #(.SRC_W(SRC_W)) i1 ();
  tl_a_rr_arbiter_if #(.SRC_W(SRC_W)) o ();

  assign i0.valid = v[0];      assign i1.valid = v[1];
  assign i0.opcode = f_op[0];  assign i1.opcode = f_op[1];
  assign i0.param = f_prm[0];  assign i1.param = f_prm[1];
  assign i0.size = f_sz[0];    assign i1.size = f_sz[1];
  assign i0.source = f_src[0]; assign i1.source = f_src[1];
  assign i0.address = f_adr[0];assign i1.address = f_adr[1];
  assign i0.mask = f_msk[0];   assign i1.mask = f_msk[1];
  assign i0.data = f_dat[0];   assign i1.data = f_dat[1];
  assign i0.corrupt = f_cor[0];assign i1.corrupt = f_cor[1];
  assign rdy[0] = i0.ready;    assign rdy[1] = i1.ready;
  assign o.ready = out_ready;

  tl_a_rr_arbiter #(.SRC_W(SRC_W), .MAX_SIZE(MAX_SIZE)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in0       (i0),
    .in1       (i1),
    .out       (o),
    .out_grant (out_grant),
    .size_err  (size_err)
  );

  beat_t stim_q[2][$];
  beat_t exp_q[2][$];
  int    grant_log[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_se_obs = 0;
  int    rpct = 100;
  int    waitc[2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Number of 8-byte beats a transfer occupies on the bus.
  function automatic int n_beats(input logic [2:0] op, input logic [2:0] sz);
    int bytes;
    if (int'(sz) > MAX_SIZE) return 1;
    if (op > 3'd3) return 1;
    bytes = 1 << sz;
    return (bytes + 7) / 8;
  endfunction

  function automatic logic [127:0] pk(input beat_t b);
    return {10'b0, b.op, b.prm, b.sz, b.src, b.adr, b.msk, b.dat, b.cor};
  endfunction

  function automatic logic [127:0] pk_out();
    return {10'b0, o.opcode, o.param, o.size, o.source, o.address, o.mask, o.data, o.corrupt};
  endfunction

  task automatic gen_txn(input int g, input logic [2:0] op, input logic [2:0] sz,
                         input int gap_first, input int gap_mid);
    beat_t b;
    int    nb;
    nb    = n_beats(op, sz);
    b.op  = op;
    b.sz  = sz;
    b.prm = 3'($urandom_range(0, 7));
    b.src = SRC_W'($urandom);
    b.adr = $urandom;
    for (int i = 0; i < nb; i++) begin
      b.msk = 8'($urandom);
      b.dat = {$urandom, $urandom};
      b.cor = ($urandom_range(0, 15) == 0);
      b.gap = (i == 0) ? gap_first : gap_mid;
      stim_q[g].push_back(b);
    end
  endtask

  task automatic present(input int g);
    beat_t b;
    b = stim_q[g].pop_front();
    f_op[g] = b.op;   f_prm[g] = b.prm; f_sz[g] = b.sz;  f_src[g] = b.src;
    f_adr[g] = b.adr; f_msk[g] = b.msk; f_dat[g] = b.dat; f_cor[g] = b.cor;
    v[g] = 1'b1;
    exp_q[g].push_back(b);
  endtask

  // One clock: note handshakes before the edge, update drive after it.
  task automatic step();
    bit a[2];
    @(negedge clock);
    for (int g = 0; g < 2; g++) a[g] = v[g] && rdy[g];
    @(posedge clock);
    #1;
    for (int g = 0; g < 2; g++) begin
      if (a[g]) v[g] = 1'b0;
      if (!v[g] && stim_q[g].size() > 0) begin
        if (waitc[g] < stim_q[g][0].gap) waitc[g]++;
        else begin
          present(g);
          waitc[g] = 0;
        end
      end
    end
    out_ready = (rpct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < rpct);
  endtask

  task automatic drain(input string nm);
    int cyc;
    cyc = 0;
    while ((stim_q[0].size() + stim_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
           && cyc < 20000) begin
      step();
      cyc++;
    end
    chk({nm, "_drained"}, (cyc < 20000), 1);
    step();
  endtask

  // Grant order: bit i of pat is the requester of the i-th fire.
  task automatic chk_log(input string nm, input int n, input logic [15:0] pat);
    logic [15:0] obs;
    obs = '0;
    for (int i = 0; i < grant_log.size() && i < 16; i++) obs[i] = (grant_log[i] != 0);
    chk({nm, "_count"}, grant_log.size(), n);
    chk({nm, "_order"}, obs, pat);
  endtask

  // Monitor: transaction-level model of who must own the bus each cycle.
  initial begin : mon
    int    g, rem, owner, held_g, nb;
    bit    prio_m, stalled, se_pend;
    beat_t b;
    rem = 0; owner = 0; held_g = 0; prio_m = 0; stalled = 0; se_pend = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        chk("rst_out_valid", o.valid, 0);
        chk("rst_ready0", rdy[0], 0);
        chk("rst_ready1", rdy[1], 0);
        rem = 0; prio_m = 0; stalled = 0; se_pend = 0;
      end else begin
        chk("size_err", size_err, se_pend);
        if (size_err) n_se_obs++;
        se_pend = 0;
        g = out_grant ? 1 : 0;
        if (rem > 0) begin
          chk("lock_grant", g, owner);
          chk("lock_valid", o.valid, v[owner]);
        end else begin
          chk("idle_valid", o.valid, v[0] | v[1]);
          if (o.valid) begin
            if (stalled) chk("stall_grant", g, held_g);
            else chk("rr_grant", g, (v[0] && v[1]) ? int'(prio_m) : (v[1] ? 1 : 0));
          end
        end
        chk("ready_sel", rdy[g], out_ready);
        chk("ready_other", rdy[1-g], 0);
        if (o.valid) begin
          chk("beat_pending", exp_q[g].size(), 1);
          if (exp_q[g].size() > 0) begin
            chk("beat_fields", pk_out(), pk(exp_q[g][0]));
            if (out_ready) begin
              b = exp_q[g].pop_front();
              grant_log.push_back(g);
              if (rem > 0) begin
                rem--;
                if (rem == 0) prio_m = (owner == 0);
              end else begin
                stalled = 0;
                if (int'(b.sz) > MAX_SIZE) se_pend = 1;
                nb = n_beats(b.op, b.sz);
                if (nb > 1) begin
                  rem   = nb - 1;
                  owner = g;
                end else prio_m = (g == 0);
              end
            end else if (rem == 0) begin
              stalled = 1;
              held_g  = g;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int se0;
    int guard;
    reset_n   = 1'b0;
    out_ready = 1'b0;
    for (int g = 0; g < 2; g++) begin
      v[g] = 1'b0; f_op[g] = '0; f_prm[g] = '0; f_sz[g] = '0; f_src[g] = '0;
      f_adr[g] = '0; f_msk[g] = '0; f_dat[g] = '0; f_cor[g] = 1'b0; waitc[g] = 0;
    end

    // Reset with both requesters valid, then in0 must win first.
    rpct = 100;
    gen_txn(0, 3'd4, 3'd3, 0, 0);
    gen_txn(1, 3'd4, 3'd3, 0, 0);
    repeat (3) step();
    chk("rst_dir_valid", o.valid, 0);
    chk("rst_dir_ready0", rdy[0], 0);
    chk("rst_dir_ready1", rdy[1], 0);
    chk("rst_dir_grant", out_grant, 0);
    chk("rst_dir_size_err", size_err, 0);
    reset_n = 1'b1;
    grant_log.delete();
    drain("t1");
    chk_log("reset_first", 2, 16'b10);

    // Alternation of single-beat Gets.
    grant_log.delete();
    for (int k = 0; k < 2; k++) begin
      gen_txn(0, 3'd4, 3'd3, 0, 0);
      gen_txn(1, 3'd4, 3'd3, 0, 0);
    end
    drain("t2");
    chk_log("alternate", 4, 16'b1010);

    // 8-beat PutFull from in0 holds the grant against a waiting in1 Get.
    grant_log.delete();
    gen_txn(0, 3'd0, 3'd6, 0, 0);
    gen_txn(1, 3'd4, 3'd3, 0, 0);
    drain("t3");
    chk_log("burst_lock", 9, 16'h0100);

    // Stalled in1 request keeps its grant when in0 shows up.
    grant_log.delete();
    rpct = 0;
    gen_txn(1, 3'd4, 3'd3, 0, 0);
    step();
    step();
    gen_txn(0, 3'd4, 3'd3, 0, 0);
    step();
    chk("stall_dir_grant", out_grant, 1);
    step();
    chk("stall_dir_grant2", out_grant, 1);
    rpct = 100;
    drain("t4");
    chk_log("stall", 2, 16'b01);

    // 2-beat burst from in1 with a 2-cycle bubble; in0 waits it out.
    grant_log.delete();
    gen_txn(1, 3'd0, 3'd4, 0, 2);
    gen_txn(0, 3'd4, 3'd3, 0, 0);
    drain("t5");
    chk_log("bubble", 3, 16'b011);

    // Oversized Get and PutFull each pass as one beat with a size_err pulse.
    grant_log.delete();
    se0 = n_se_obs;
    gen_txn(0, 3'd4, 3'd7, 0, 0);
    gen_txn(0, 3'd0, 3'd7, 0, 0);
    drain("t6");
    chk_log("oversize", 2, 16'b00);
    chk("size_err_pulses", n_se_obs - se0, 2);

    // Reset after beat 3 of an 8-beat burst; priority must restart at in0.
    grant_log.delete();
    gen_txn(0, 3'd0, 3'd6, 0, 0);
    guard = 0;
    while (grant_log.size() < 3 && guard < 100) begin
      step();
      guard++;
    end
    chk("t7_three_beats", grant_log.size(), 3);
    reset_n = 1'b0;
    stim_q[0].delete();
    exp_q[0].delete();
    v[0] = 1'b0;
    waitc[0] = 0;
    repeat (2) step();
    chk("midrst_grant", out_grant, 0);
    reset_n = 1'b1;
    step();
    chk("midrst_idle", o.valid, 0);
    grant_log.delete();
    gen_txn(1, 3'd4, 3'd3, 0, 0);
    gen_txn(0, 3'd4, 3'd3, 0, 0);
    drain("t7");
    chk_log("midrst_prio", 2, 16'b10);

    // Random traffic with downstream back-pressure and valid gaps.
    rpct = 75;
    for (int k = 0; k < 150; k++) begin
      for (int g = 0; g < 2; g++) begin
        gen_txn(g, 3'($urandom_range(0, 5)),
                ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
